// File: rtl/player_motion.sv
// Per-frame vertical physics for the player sprite: jump launch, gravity, fall clamp, landing.
// Optional feature: define PLAYER_DOUBLE_JUMP_EN to allow one extra jump per airborne period.
module player_motion #(
  parameter int START_X  = 100,
  parameter int GROUND_Y = 400,
  parameter int SIZE     = 15,
  parameter int JUMP_VEL = -12,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 12
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       jump,
  input  logic       halt,
  output logic [9:0] spriteX,
  output logic [9:0] spriteY,
  output logic [9:0] sprite_size,
  output logic       airborne,
  output logic [7:0] vel_y
);

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    RISING   = 2'd1,
    FALLING  = 2'd2
  } state_t;

  localparam logic signed [10:0] GY11  = 11'(GROUND_Y);
  localparam logic signed [10:0] JV11  = 11'(JUMP_VEL);
  localparam logic signed [7:0]  LV8   = 8'(JUMP_VEL + GRAVITY);
  localparam logic signed [8:0]  G9    = 9'(GRAVITY);
  localparam logic signed [8:0]  MF9   = 9'(MAX_FALL);

  state_t            state_q, state_d;
  logic signed [10:0] y_q, y_d;
  logic signed [7:0]  v_q, v_d;
  logic               jp_q, jp_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
  logic               used_q, used_d;
`endif

  logic               tick_ok;
  logic               launch;
  logic signed [10:0] v_ext;
  logic signed [8:0]  v_sum;
  logic signed [10:0] y_nx;
  logic signed [7:0]  v_nx;
  state_t             st_nx;

  assign tick_ok = frame_tick && !halt;
  assign v_ext   = {{3{v_q[7]}}, v_q};
  assign v_sum   = {v_q[7], v_q} + G9;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    v_d     = v_q;
    jp_d    = jp_q;
`ifdef PLAYER_DOUBLE_JUMP_EN
    used_d  = used_q;
`endif
    launch  = 1'b0;
    y_nx    = y_q + v_ext;
    v_nx    = (v_sum > MF9) ? MF9[7:0] : v_sum[7:0];
    st_nx   = (state_q == RISING && v_nx[7]) ? RISING : FALLING;

    if (tick_ok) begin
      jp_d = jump;
      if (state_q == GROUNDED && jump)
        launch = 1'b1;
`ifdef PLAYER_DOUBLE_JUMP_EN
      if (state_q != GROUNDED && jump && !jp_q && !used_q) begin
        launch = 1'b1;
        used_d = 1'b1;
      end
`endif
      if (launch) begin
        y_nx  = y_q + JV11;
        v_nx  = LV8;
        st_nx = RISING;
      end
      // Launches share the landing/ceiling checks so a tall jump from a low ground clips at 0.
      if (launch || state_q != GROUNDED) begin
        if (y_nx >= GY11) begin
          y_d     = GY11;
          v_d     = '0;
          state_d = GROUNDED;
`ifdef PLAYER_DOUBLE_JUMP_EN
          used_d  = 1'b0;
`endif
        end else if (y_nx[10]) begin
          y_d     = '0;
          v_d     = '0;
          state_d = FALLING;
        end else begin
          y_d     = y_nx;
          v_d     = v_nx;
          state_d = st_nx;
        end
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_q <= GROUNDED;
      y_q     <= GY11;
      v_q     <= '0;
      jp_q    <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
      used_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      v_q     <= v_d;
      jp_q    <= jp_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
      used_q  <= used_d;
`endif
    end
  end

  assign spriteX     = 10'(START_X);
  assign sprite_size = 10'(SIZE);
  assign spriteY     = y_q[9:0];
  assign airborne    = (state_q != GROUNDED);
  assign vel_y       = v_q;

endmodule
